// File: rtl/circl_raster.sv
// Raster-side consumer of the circle half-width LUT: beam counters, LUT addressing and per-pixel
// "inside circle" flag. Define CIRCL_RING_EN for outline (ring) drawing instead of a filled disc.
module circl_raster #(
    parameter int HCW  = 9,
    parameter int VCW  = 9,
    parameter int RMAX = 29
) (
    input  logic           fclk,
    input  logic           rst_n,
    input  logic           pix_stb,
    input  logic           line_start,
    input  logic           frame_start,
    input  logic [HCW-1:0] pos_x,
    input  logic [VCW-1:0] pos_y,
    input  logic           pos_we,
    output logic [4:0]     lut_addr,
    input  logic [4:0]     lut_data,
    output logic           pixel_on
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [4:0]     ADDR_TOP = 5'(RMAX + 1);
    localparam logic [VCW-1:0] DY_MAX   = VCW'(RMAX);

    logic [1:0]     state;
    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic [HCW-1:0] cx, pend_x;
    logic [VCW-1:0] cy, pend_y;
    logic [4:0]     hw;
    logic           row_act;
    logic           dy_ok_q;
    logic           row_edge;

    function automatic logic [HCW-1:0] sat_inc(input logic [HCW-1:0] v);
        return (v == '1) ? v : v + HCW'(1);
    endfunction

    function automatic logic [HCW-1:0] absdiff_h(input logic [HCW-1:0] a, input logic [HCW-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [VCW-1:0] absdiff_v(input logic [VCW-1:0] a, input logic [VCW-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Line setup: the centre loaded at frame_start is already visible to a coincident line_start.
    logic [VCW-1:0] vcnt_nxt, cy_nxt, dy_nxt;
    logic [HCW-1:0] cx_nxt;
    logic           dy_ok_nxt;

    always_comb begin
        vcnt_nxt  = frame_start ? '0 : vcnt + VCW'(1);
        cx_nxt    = pos_we ? pos_x : pend_x;
        cy_nxt    = frame_start ? (pos_we ? pos_y : pend_y) : cy;
        dy_nxt    = absdiff_v(vcnt_nxt, cy_nxt);
        dy_ok_nxt = (dy_nxt <= DY_MAX);
    end

    // Pixel evaluation on the pre-increment horizontal count.
    logic [HCW-1:0] dx, hw_x;
    logic [HCW:0]   dx_p1;
    logic           hit;

    always_comb begin
        dx    = absdiff_h(hcnt, cx);
        hw_x  = HCW'(hw);
        dx_p1 = {1'b0, dx} + (HCW+1)'(1);
`ifdef CIRCL_RING_EN
        hit   = (dx == hw_x) || (dx_p1 == {1'b0, hw_x}) || (row_edge && (dx <= hw_x));
`else
        hit   = (dx <= hw_x);
`endif
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hcnt     <= '0;
            vcnt     <= '1;
            cx       <= '0;
            cy       <= '0;
            pend_x   <= '0;
            pend_y   <= '0;
            hw       <= '0;
            row_act  <= 1'b0;
            dy_ok_q  <= 1'b0;
            row_edge <= 1'b0;
            lut_addr <= '0;
            pixel_on <= 1'b0;
        end else begin
            if (pos_we) begin
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
            if (frame_start) begin
                cx <= cx_nxt;
                cy <= cy_nxt;
            end

            if (line_start)
                vcnt <= vcnt_nxt;
            else if (frame_start)
                vcnt <= '1;

            if (line_start)
                hcnt <= '0;
            else if (pix_stb)
                hcnt <= sat_inc(hcnt);

            if (line_start) begin
                state    <= S_SETUP;
                row_act  <= 1'b0;
                pixel_on <= 1'b0;
                dy_ok_q  <= dy_ok_nxt;
                row_edge <= (dy_nxt == DY_MAX);
                lut_addr <= dy_ok_nxt ? ADDR_TOP - dy_nxt[4:0] : 5'd0;
            end else begin
                if (pix_stb)
                    pixel_on <= row_act && (state == S_RUN) && hit;
                case (state)
                    S_SETUP: begin
                        hw      <= lut_data;
                        row_act <= dy_ok_q;
                        state   <= S_LATCH;
                    end
                    S_LATCH: state <= S_RUN;
                    S_RUN:   if (hcnt == '1) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_circl_raster.sv
// Self-checking bench for circl_raster: directed scenarios plus randomized centres/lines
// compared against a geometric reference model of the disc (or ring).
module tb_circl_raster;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_stb = 1'b0;
    logic       line_start = 1'b0;
    logic       frame_start = 1'b0;
    logic       pos_we = 1'b0;
    logic [8:0] pos_x = '0;
    logic [8:0] pos_y = '0;
    logic [4:0] lut_addr;
    logic [4:0] lut_data;
    logic       pixel_on;

    logic [4:0] rom [0:31];
    assign lut_data = rom[lut_addr];

    circl_raster #(.HCW(9), .VCW(9), .RMAX(29)) dut (
        .fclk(fclk), .rst_n(rst_n), .pix_stb(pix_stb), .line_start(line_start),
        .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we),
        .lut_addr(lut_addr), .lut_data(lut_data), .pixel_on(pixel_on)
    );

    always #5 fclk = ~fclk;

    int n_chk = 0;
    int n_pass = 0;
    int m_line, m_h, m_cx, m_cy, m_px, m_py;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Circle of radius ~29.5: half-width of row at vertical distance dy.
    function automatic int exp_addr(input int line);
        int dy = iabs(line - m_cy);
        return (dy <= 29) ? 30 - dy : 0;
    endfunction

    function automatic bit exp_pix(input int line, input int h);
        int dy = iabs(line - m_cy);
        int dx = iabs(h - m_cx);
        int hwv;
        if (dy > 29) return 1'b0;
        hwv = isqrt(870 - dy * dy);
`ifdef CIRCL_RING_EN
        return (dx == hwv) || (dx + 1 == hwv) || ((dy == 29) && (dx <= hwv));
`else
        return dx <= hwv;
`endif
    endfunction

    task automatic cyc();
        @(posedge fclk);
        #1;
    endtask

    task automatic start_frame(input bit we, input int x, input int y);
        if (we) begin
            m_px = x;
            m_py = y;
        end
        frame_start = 1'b1;
        line_start  = 1'b1;
        pos_we      = we;
        pos_x       = 9'(x);
        pos_y       = 9'(y);
        cyc();
        frame_start = 1'b0;
        line_start  = 1'b0;
        pos_we      = 1'b0;
        m_cx = m_px;
        m_cy = m_py;
        m_line = 0;
        m_h = 0;
    endtask

    task automatic advance_to(input int l);
        while (m_line < l) begin
            line_start = 1'b1;
            cyc();
            m_line++;
        end
        line_start = 1'b0;
        m_h = 0;
    endtask

    task automatic write_pos(input int x, input int y);
        pos_we = 1'b1;
        pos_x  = 9'(x);
        pos_y  = 9'(y);
        cyc();
        pos_we = 1'b0;
        m_px = x;
        m_py = y;
    endtask

    task automatic to_run();
        cyc();
        cyc();
    endtask

    task automatic pix();
        pix_stb = 1'b1;
        cyc();
        pix_stb = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if (lut_addr !== 5'd0) $display("FAIL reset_lut_addr: got %0d want 0", lut_addr);
        else n_pass++;
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL reset_pixel_on: got %b want 0", pixel_on);
        else n_pass++;
        #4 rst_n = 1'b1;
        cyc();
        m_px = 0; m_py = 0; m_cx = 0; m_cy = 0; m_line = 0; m_h = 0;
    endtask

    task automatic test_fill_centre();
        bit want;
        start_frame(1'b1, 100, 80);
        advance_to(80);
        n_chk++;
        if (lut_addr !== 5'd30) $display("FAIL centre_lut_addr: got %0d want 30", lut_addr);
        else n_pass++;
        to_run();
        for (int h = 0; h <= 140; h++) begin
            pix();
`ifdef CIRCL_RING_EN
            want = (h == 71) || (h == 72) || (h == 128) || (h == 129);
`else
            want = (h >= 71) && (h <= 129);
`endif
            n_chk++;
            if (pixel_on !== want) $display("FAIL centre_row h=%0d: got %b want %b", h, pixel_on, want);
            else n_pass++;
        end
    endtask

    task automatic test_edge_rows();
        bit want;
        start_frame(1'b1, 100, 80);
        advance_to(50);
        n_chk++;
        if (lut_addr !== 5'd0) $display("FAIL row50_lut_addr: got %0d want 0", lut_addr);
        else n_pass++;
        to_run();
        for (int h = 0; h <= 200; h++) begin
            pix();
            n_chk++;
            if (pixel_on !== 1'b0) $display("FAIL row50 h=%0d: got %b want 0", h, pixel_on);
            else n_pass++;
        end
        advance_to(51);
        n_chk++;
        if (lut_addr !== 5'd1) $display("FAIL row51_lut_addr: got %0d want 1", lut_addr);
        else n_pass++;
        to_run();
        for (int h = 0; h <= 120; h++) begin
            pix();
            want = (h >= 95) && (h <= 105);
            n_chk++;
            if (pixel_on !== want) $display("FAIL row51 h=%0d: got %b want %b", h, pixel_on, want);
            else n_pass++;
        end
    endtask

    task automatic test_setup_strobe();
        bit want;
        start_frame(1'b1, 100, 80);
        advance_to(80);
        pix();
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL setup_strobe: got %b want 0", pixel_on);
        else n_pass++;
        pix();
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL latch_strobe: got %b want 0", pixel_on);
        else n_pass++;
        for (int h = 2; h < 100; h++) pix();
        pix();
`ifdef CIRCL_RING_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        n_chk++;
        if (pixel_on !== want) $display("FAIL run_h100: got %b want %b", pixel_on, want);
        else n_pass++;
        repeat (3) cyc();
        n_chk++;
        if (pixel_on !== want) $display("FAIL hold_h100: got %b want %b", pixel_on, want);
        else n_pass++;
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        m_line++;
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL line_start_clear: got %b want 0", pixel_on);
        else n_pass++;
    endtask

    task automatic test_centre_update();
        bit want;
        start_frame(1'b1, 100, 80);
        advance_to(40);
        write_pos(100, 200);
        advance_to(80);
        to_run();
        for (int h = 0; h <= 140; h++) begin
            pix();
            want = exp_pix(80, h);
            n_chk++;
            if (pixel_on !== want) $display("FAIL old_centre h=%0d: got %b want %b", h, pixel_on, want);
            else n_pass++;
        end
        start_frame(1'b0, 0, 0);
        advance_to(200);
        n_chk++;
        if (lut_addr !== 5'd30) $display("FAIL new_centre_lut_addr: got %0d want 30", lut_addr);
        else n_pass++;
        to_run();
        for (int h = 0; h <= 140; h++) begin
            pix();
            want = exp_pix(200, h);
            n_chk++;
            if (pixel_on !== want) $display("FAIL new_centre h=%0d: got %b want %b", h, pixel_on, want);
            else n_pass++;
        end
        start_frame(1'b1, 150, 50);
        advance_to(50);
        n_chk++;
        if (lut_addr !== 5'd30) $display("FAIL same_cycle_lut_addr: got %0d want 30", lut_addr);
        else n_pass++;
        to_run();
        for (int h = 0; h <= 190; h++) begin
            pix();
            want = exp_pix(50, h);
            n_chk++;
            if (pixel_on !== want) $display("FAIL same_cycle h=%0d: got %b want %b", h, pixel_on, want);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int cx, cy, line, lo, hi, wa;
        bit want;
        for (int k = 0; k < 12; k++) begin
            cx = int'($urandom_range(0, 450));
            cy = int'($urandom_range(0, 300));
            line = cy + int'($urandom_range(0, 70)) - 35;
            if (line < 0) line = 0;
            start_frame(1'b1, cx, cy);
            advance_to(line);
            wa = exp_addr(line);
            n_chk++;
            if (lut_addr !== 5'(wa)) $display("FAIL rand_lut_addr k=%0d: got %0d want %0d", k, lut_addr, wa);
            else n_pass++;
            to_run();
            lo = (cx > 40) ? cx - 40 : 0;
            hi = (cx + 40 < 510) ? cx + 40 : 510;
            for (int h = 0; h <= hi; h++) begin
                pix();
                if ($urandom_range(0, 3) == 0) cyc();
                if (h >= lo) begin
                    want = exp_pix(line, h);
                    n_chk++;
                    if (pixel_on !== want)
                        $display("FAIL rand k=%0d c=(%0d,%0d) line=%0d h=%0d: got %b want %b",
                                 k, cx, cy, line, h, pixel_on, want);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        bit want;
        start_frame(1'b1, 100, 80);
        advance_to(80);
        to_run();
        for (int h = 0; h <= 100; h++) pix();
        want = exp_pix(80, 100);
        n_chk++;
        if (pixel_on !== want) $display("FAIL pre_reset: got %b want %b", pixel_on, want);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL midline_reset_pixel_on: got %b want 0", pixel_on);
        else n_pass++;
        n_chk++;
        if (lut_addr !== 5'd0) $display("FAIL midline_reset_lut_addr: got %0d want 0", lut_addr);
        else n_pass++;
        #3 rst_n = 1'b1;
        cyc();
        m_px = 0; m_py = 0; m_cx = 0; m_cy = 0;
        for (int h = 0; h < 40; h++) begin
            pix();
            n_chk++;
            if (pixel_on !== 1'b0) $display("FAIL post_reset h=%0d: got %b want 0", h, pixel_on);
            else n_pass++;
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            if (a >= 1 && a <= 30) rom[a] = 5'(isqrt(870 - (30 - a) * (30 - a)));
            else rom[a] = 5'd31;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_centre();
        test_edge_rows();
        test_setup_strobe();
        test_centre_update();
        test_random();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
